btb_way_array: RTL

- Parametrised set-associative branch-target-buffer storage; successor to the fixed 8-set single-vector BTB file.
- Holds per-way valid/tag/target/2-bit direction counter.
- Provides a combinational lookup port with same-cycle update forwarding, and a registered update/allocate port with round-robin replacement.
- Provides a multi-cycle flush engine. Sits between the fetch-stage predictor (lookup) and the execute-stage branch resolver (update).

---
 rtl/btb_way_array.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/btb_way_array.sv
// Set-associative BTB storage: combinational lookup with same-cycle update
// forwarding, registered update/allocate with round-robin victims, multi-cycle flush.

module btb_way_cmp #(
  parameter int TAG_W = 27
) (
  input  logic             valid,
  input  logic [TAG_W-1:0] way_tag,
  input  logic [TAG_W-1:0] key,
  output logic             hit
);
  assign hit = valid && (way_tag == key);
endmodule

module btb_way_array #(
  parameter  int SETS  = 8,
  parameter  int WAYS  = 2,
  parameter  int TAG_W = 27,
  parameter  int TGT_W = 32,
  localparam int IDX_W = $clog2(SETS),
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] lk_index,
  input  logic [TAG_W-1:0] lk_tag,
  output logic             lk_hit,
  output logic [WAY_W-1:0] lk_way,
  output logic [TGT_W-1:0] lk_target,
  output logic             lk_taken,
  input  logic             up_valid,
  input  logic [IDX_W-1:0] up_index,
  input  logic [TAG_W-1:0] up_tag,
  input  logic [TGT_W-1:0] up_target,
  input  logic             up_taken,
  input  logic             flush_req,
  output logic             busy
);
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_FLUSH = 1'b1;

  logic [WAYS-1:0]             valid_q [SETS];
  logic [WAYS-1:0][1:0]        ctr_q   [SETS];
  logic [WAYS-1:0][TAG_W-1:0]  tag_q   [SETS];
  logic [WAYS-1:0][TGT_W-1:0]  tgt_q   [SETS];
  logic [WAY_W-1:0]            rr_q    [SETS];
  logic [0:0]                  state_q;
  logic [IDX_W-1:0]            flush_idx_q;

  logic                        up_en;
  logic [WAYS-1:0]             up_hit_vec;
  logic                        up_hit, has_free, up_evict;
  logic [WAY_W-1:0]            hit_way, free_way, up_way, rr_nxt;
  logic [1:0]                  old_ctr, new_ctr;
  logic [WAYS-1:0]             nxt_valid;
  logic [WAYS-1:0][1:0]        nxt_ctr;
  logic [WAYS-1:0][TAG_W-1:0]  nxt_tag;
  logic [WAYS-1:0][TGT_W-1:0]  nxt_tgt;

  logic                        fwd;
  logic [WAYS-1:0]             lk_valid;
  logic [WAYS-1:0][1:0]        lk_ctr;
  logic [WAYS-1:0][TAG_W-1:0]  lk_tags;
  logic [WAYS-1:0][TGT_W-1:0]  lk_tgts;
  logic [WAYS-1:0]             lk_hit_vec;

  assign busy  = (state_q == S_FLUSH);
  assign up_en = up_valid && !busy;

  // Lookup sees the post-edge image of its set when an update targets it.
  assign fwd      = up_en && (up_index == lk_index);
  assign lk_valid = fwd ? nxt_valid : valid_q[lk_index];
  assign lk_ctr   = fwd ? nxt_ctr   : ctr_q[lk_index];
  assign lk_tags  = fwd ? nxt_tag   : tag_q[lk_index];
  assign lk_tgts  = fwd ? nxt_tgt   : tgt_q[lk_index];

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    btb_way_cmp #(.TAG_W(TAG_W)) u_up_cmp (
      .valid   (valid_q[up_index][w]),
      .way_tag (tag_q[up_index][w]),
      .key     (up_tag),
      .hit     (up_hit_vec[w])
    );
    btb_way_cmp #(.TAG_W(TAG_W)) u_lk_cmp (
      .valid   (lk_valid[w]),
      .way_tag (lk_tags[w]),
      .key     (lk_tag),
      .hit     (lk_hit_vec[w])
    );
  end

  always_comb begin
    has_free = 1'b0;
    free_way = '0;
    hit_way  = '0;
    for (int w = WAYS-1; w >= 0; w--) begin
      if (!valid_q[up_index][w]) begin
        has_free = 1'b1;
        free_way = WAY_W'(w);
      end
    end
    for (int w = 0; w < WAYS; w++)
      if (up_hit_vec[w]) hit_way = WAY_W'(w);
    up_hit   = |up_hit_vec;
    up_evict = !up_hit && !has_free;
    up_way   = up_hit ? hit_way : (has_free ? free_way : rr_q[up_index]);
    rr_nxt   = (rr_q[up_index] == WAY_W'(WAYS-1)) ? '0 : rr_q[up_index] + 1'b1;

    old_ctr = ctr_q[up_index][up_way];
    if (up_hit) begin
      if (up_taken) new_ctr = (old_ctr == 2'b11) ? 2'b11 : old_ctr + 2'd1;
      else          new_ctr = (old_ctr == 2'b00) ? 2'b00 : old_ctr - 2'd1;
    end else begin
      new_ctr = up_taken ? 2'b10 : 2'b01;
    end

    nxt_valid = valid_q[up_index];
    nxt_ctr   = ctr_q[up_index];
    nxt_tag   = tag_q[up_index];
    nxt_tgt   = tgt_q[up_index];
    nxt_valid[up_way] = 1'b1;
    nxt_ctr[up_way]   = new_ctr;
    nxt_tag[up_way]   = up_tag;
    nxt_tgt[up_way]   = up_target;
  end

  always_comb begin
    lk_hit    = 1'b0;
    lk_way    = '0;
    lk_target = '0;
    lk_taken  = 1'b0;
    if (!busy) begin
      for (int w = 0; w < WAYS; w++) begin
        if (lk_hit_vec[w]) begin
          lk_hit    = 1'b1;
          lk_way    = WAY_W'(w);
          lk_target = lk_tgts[w];
          lk_taken  = lk_ctr[w][1];
        end
      end
    end
  end

  // Updates can only commit in IDLE, so they never race the flush writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      flush_idx_q <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        ctr_q[s]   <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (flush_req) begin
            state_q     <= S_FLUSH;
            flush_idx_q <= '0;
          end
        end
        default: begin
          valid_q[flush_idx_q] <= '0;
          rr_q[flush_idx_q]    <= '0;
          if (flush_idx_q == IDX_W'(SETS-1)) state_q <= S_IDLE;
          else                               flush_idx_q <= flush_idx_q + 1'b1;
        end
      endcase
      if (up_en) begin
        valid_q[up_index] <= nxt_valid;
        ctr_q[up_index]   <= nxt_ctr;
        if (up_evict) rr_q[up_index] <= rr_nxt;
      end
    end
  end

  // Tag/target are qualified by valid, so they need no reset.
  always_ff @(posedge clk) begin
    if (up_en) begin
      tag_q[up_index] <= nxt_tag;
      tgt_q[up_index] <= nxt_tgt;
    end
  end

endmodule
